rplidar_scan_decoder: RTL and testbench
=======================================

# rplidar_scan_decoder

Byte-stream decoder that sits directly downstream of the 115200-baud UART receiver and upstream of the distance/LED logic. It consumes `rx_data`/`rx_valid` after a Normal Scan (`A5 20`) command has been issued. It first strips the 7-byte response descriptor, then decodes 5-byte measurement nodes with full check-bit validation. Each valid node is presented as one-cycle-strobed quality, angle and distance fields, and framing errors are counted for debug LEDs.

## Interface
- `CLK_FREQ`, 100_000_000, clock frequency in Hz.
- `GAP_TIMEOUT_US`, 200, maximum idle gap between bytes of one node before resync.
- `SKIP_DESCRIPTOR`, 1, 1 = expect `A5 5A 05 00 00 40 81` before nodes; 0 = start directly in node parsing.

Ports:
- `clk_100mhz`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high reset.
- `restart`  in  1  synchronous pulse; returns to descriptor wait (issued with each new scan command).
- `rx_data`  in  8  byte from UART RX.
- `rx_valid`  in  1  one-cycle strobe qualifying `rx_data`.
- `meas_valid`  out  1  one-cycle strobe; the fields below are valid.
- `meas_quality`  out  6  byte0[7:2].
- `meas_start`  out  1  S bit: first node of a new 360° revolution.
- `meas_angle_q6`  out  15  {byte2, byte1[7:1]}; degrees ×64.
- `meas_distance_mm`  out  14  {byte4, byte3} >> 2; 0 = no return.
- `desc_locked`  out  1  high once the descriptor has matched, or constant 1 when `SKIP_DESCRIPTOR` = 0.
- `err_count`  out  16  saturating count of rejected bytes/nodes and gap timeouts.

## Operation
- States: `DESC` (index 0..6), `B0`, `B1`, `B2`, `B3`, `B4`.
- **DESC:**
  - On each `rx_valid`, compare against the expected descriptor byte at the current index.
  - Match → index+1; a match at index 6 → `B0` and `desc_locked` = 1.
  - Mismatch → index = 1 if the byte is `A5`, else 0. Mismatches in `DESC` do not increment `err_count`.
- **B0:** accept only if bit0 ≠ bit1. Otherwise stay in `B0` and increment `err_count`, discarding one byte at a time (sliding resync).
- **B1:** requires bit0 (C) = 1. Otherwise `err_count`+1 and go to `B0`; the offending byte is not re-examined as a B0 candidate.
- **B2, B3:** unconditional capture.
- **B4:**
  - Capture the byte and assemble the node.
  - Pulse `meas_valid` if the node is well formed, then go to `B0`.
  - Distance is shifted right by 2, discarding the fractional bits; the top of the 16-bit raw value truncates into 14 bits, so there is no overflow.
- **Gap timer:**
  - Counts cycles since the last `rx_valid` while in `B1`..`B4`.
  - Reaching `GAP_TIMEOUT_US*CLK_FREQ/1e6` → `B0`, `err_count`+1, partial node discarded.
  - The timer is inactive in `DESC` and `B0`.
- **Counter saturation:** `err_count` saturates at `FFFF`.
- **`restart`:** goes to `DESC` index 0 (or `B0` if `SKIP_DESCRIPTOR` = 0), clears `desc_locked`, and preserves `err_count`.

## Timing
- All outputs reset to 0, except `desc_locked`, which resets to `~SKIP_DESCRIPTOR`.
- Latency: `meas_valid` and all `meas_*` fields are registered and asserted exactly 1 cycle after the `rx_valid` carrying byte4.
- `meas_*` fields hold their values until the next `meas_valid`.
- `meas_valid` is never high on two consecutive cycles. Bytes are at least 868 cycles apart, but the block must not rely on this.
- Simultaneous events:
  - `restart` with `rx_valid`: `restart` wins and the byte is discarded.
  - Timeout with `rx_valid` in the same cycle: the byte wins and the timer clears.
- Reset mid-node: all partial capture registers clear, with no `meas_valid` glitch on reset release.

## Structure
- Package `rplidar_pkg` holds:
  - descriptor byte constants (`RESP_DESC[0:6]`) and command bytes (`CMD_SYNC`=A5, `CMD_SCAN`=20);
  - the state enum;
  - field width constants (`Q6_W`=15, `DIST_W`=14, `QUAL_W`=6).
- No sub-module is required. An optional `byte_gap_timer` (counter with clear/expire) may be factored out and reused by the command sequencer.

## Test plan
- Descriptor, then node `3E 81 2D 40 1F`:
  - `desc_locked` = 1;
  - `meas_valid` 1 cycle after the last byte;
  - quality = 15, start = 0, angle_q6 = 0x16C0, distance_mm = 2000.
- Garbage `00 FF` before the descriptor, and a descriptor with a repeated `A5 A5 5A…`:
  - lock is still achieved;
  - `err_count` = 0.
- After lock, send B0 = `03` (S = !S), then a valid node: `err_count` = 1 and the valid node is decoded. Also send byte1 with C = 0: `err_count` increments, no `meas_valid`, and the next good node decodes.
- Stop after 3 node bytes for more than 200 µs, then send a full node: `err_count` +1 and only the full node is output.
- `restart` asserted mid-node, coincident with `rx_valid`: `desc_locked` = 0, the byte is ignored, and re-lock works.
- Force 70000 bad B0 bytes: `err_count` holds at `FFFF`. Distance bytes `FF FF` → distance_mm = 16383.

Source files
------------

// File: rtl/rplidar_pkg.sv
// Shared constants, state encoding and field widths for the RPLIDAR scan decoder.
package rplidar_pkg;

    localparam logic [7:0] CMD_SYNC = 8'hA5;
    localparam logic [7:0] CMD_SCAN = 8'h20;

    localparam int DESC_LEN = 7;
    localparam logic [7:0] RESP_DESC [0:6] = '{8'hA5, 8'h5A, 8'h05, 8'h00, 8'h00, 8'h40, 8'h81};

    localparam int Q6_W   = 15;
    localparam int DIST_W = 14;
    localparam int QUAL_W = 6;

    typedef enum logic [2:0] {
        ST_DESC = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_B3   = 3'd4,
        ST_B4   = 3'd5
    } scan_state_e;

    // Index 7 never occurs; it folds onto the first descriptor byte.
    function automatic logic [7:0] desc_byte(input logic [2:0] idx);
        logic [7:0] b;
        b = RESP_DESC[0];
        case (idx)
            3'd1:    b = RESP_DESC[1];
            3'd2:    b = RESP_DESC[2];
            3'd3:    b = RESP_DESC[3];
            3'd4:    b = RESP_DESC[4];
            3'd5:    b = RESP_DESC[5];
            3'd6:    b = RESP_DESC[6];
            default: b = RESP_DESC[0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/rplidar_scan_decoder_gap_timer.sv
// Inter-byte gap timer: down-counter reloaded by clear, expires at terminal count while enabled.
module rplidar_scan_decoder_gap_timer #(
    parameter int CYCLES = 20000
) (
    input  logic clk_100mhz,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LOAD = CW'(CYCLES - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            count <= LOAD;
        end else if (clear || !enable) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign expired = enable && !clear && (count == '0);

endmodule

// File: rtl/rplidar_scan_decoder.sv
// Normal-scan response decoder: strips the 7-byte descriptor, then validates and unpacks 5-byte nodes.
module rplidar_scan_decoder
    import rplidar_pkg::*;
#(
    parameter int CLK_FREQ        = 100_000_000,
    parameter int GAP_TIMEOUT_US  = 200,
    parameter bit SKIP_DESCRIPTOR = 1'b1
) (
    input  logic              clk_100mhz,
    input  logic              reset,
    input  logic              restart,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              meas_valid,
    output logic [QUAL_W-1:0] meas_quality,
    output logic              meas_start,
    output logic [Q6_W-1:0]   meas_angle_q6,
    output logic [DIST_W-1:0] meas_distance_mm,
    output logic              desc_locked,
    output logic [15:0]       err_count
);

    localparam longint GAP_CYCLES_L = longint'(GAP_TIMEOUT_US) * longint'(CLK_FREQ) / 64'sd1_000_000;
    localparam int     GAP_CYCLES   = (GAP_CYCLES_L < 1) ? 1 : int'(GAP_CYCLES_L);
    localparam scan_state_e IDLE_STATE = SKIP_DESCRIPTOR ? ST_DESC : ST_B0;

    scan_state_e state, state_n;
    logic [2:0]  desc_idx, desc_idx_n;

    logic [QUAL_W-1:0] node_qual;
    logic              node_start;
    logic [6:0]        node_b1;
    logic [7:0]        node_b2;
    logic [7:0]        node_b3;

    logic cap_b0, cap_b1, cap_b2, cap_b3;
    logic node_done, err_inc, lock_set;
    logic timer_en, gap_expired;

    assign timer_en = (state == ST_B1) || (state == ST_B2) || (state == ST_B3) || (state == ST_B4);

    rplidar_scan_decoder_gap_timer #(
        .CYCLES (GAP_CYCLES)
    ) u_gap_timer (
        .clk_100mhz (clk_100mhz),
        .reset      (reset),
        .clear      (rx_valid || restart),
        .enable     (timer_en),
        .expired    (gap_expired)
    );

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            state    <= IDLE_STATE;
            desc_idx <= 3'd0;
        end else begin
            state    <= state_n;
            desc_idx <= desc_idx_n;
        end
    end

    // restart beats an incoming byte; an incoming byte beats a gap timeout.
    always_comb begin
        state_n    = state;
        desc_idx_n = desc_idx;
        cap_b0     = 1'b0;
        cap_b1     = 1'b0;
        cap_b2     = 1'b0;
        cap_b3     = 1'b0;
        node_done  = 1'b0;
        err_inc    = 1'b0;
        lock_set   = 1'b0;
        if (restart) begin
            state_n    = IDLE_STATE;
            desc_idx_n = 3'd0;
        end else if (rx_valid) begin
            case (state)
                ST_DESC: begin
                    if (rx_data == desc_byte(desc_idx)) begin
                        if (desc_idx == 3'(DESC_LEN - 1)) begin
                            state_n    = ST_B0;
                            desc_idx_n = 3'd0;
                            lock_set   = 1'b1;
                        end else begin
                            desc_idx_n = desc_idx + 3'd1;
                        end
                    end else begin
                        desc_idx_n = (rx_data == CMD_SYNC) ? 3'd1 : 3'd0;
                    end
                end
                ST_B0: begin
                    if (rx_data[0] != rx_data[1]) begin
                        cap_b0  = 1'b1;
                        state_n = ST_B1;
                    end else begin
                        err_inc = 1'b1;
                    end
                end
                ST_B1: begin
                    if (rx_data[0]) begin
                        cap_b1  = 1'b1;
                        state_n = ST_B2;
                    end else begin
                        err_inc = 1'b1;
                        state_n = ST_B0;
                    end
                end
                ST_B2: begin
                    cap_b2  = 1'b1;
                    state_n = ST_B3;
                end
                ST_B3: begin
                    cap_b3  = 1'b1;
                    state_n = ST_B4;
                end
                ST_B4: begin
                    node_done = 1'b1;
                    state_n   = ST_B0;
                end
                default: begin
                    state_n    = IDLE_STATE;
                    desc_idx_n = 3'd0;
                end
            endcase
        end else if (gap_expired) begin
            err_inc = 1'b1;
            state_n = ST_B0;
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            node_qual  <= '0;
            node_start <= 1'b0;
            node_b1    <= '0;
            node_b2    <= '0;
            node_b3    <= '0;
        end else begin
            if (cap_b0) begin
                node_qual  <= rx_data[7:2];
                node_start <= rx_data[0];
            end
            if (cap_b1) node_b1 <= rx_data[7:1];
            if (cap_b2) node_b2 <= rx_data;
            if (cap_b3) node_b3 <= rx_data;
        end
    end

    // Byte4 is consumed straight off rx_data; the two fractional distance bits are dropped.
    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            meas_valid       <= 1'b0;
            meas_quality     <= '0;
            meas_start       <= 1'b0;
            meas_angle_q6    <= '0;
            meas_distance_mm <= '0;
        end else begin
            meas_valid <= node_done;
            if (node_done) begin
                meas_quality     <= node_qual;
                meas_start       <= node_start;
                meas_angle_q6    <= {node_b2, node_b1};
                meas_distance_mm <= {rx_data, node_b3[7:2]};
            end
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            err_count <= '0;
        end else if (err_inc && (err_count != 16'hFFFF)) begin
            err_count <= err_count + 16'd1;
        end
    end

    always_ff @(posedge clk_100mhz or posedge reset) begin
        if (reset) begin
            desc_locked <= ~SKIP_DESCRIPTOR;
        end else if (!SKIP_DESCRIPTOR) begin
            desc_locked <= 1'b1;
        end else if (restart) begin
            desc_locked <= 1'b0;
        end else if (lock_set) begin
            desc_locked <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rplidar_scan_decoder.sv
// Scoreboard bench for rplidar_scan_decoder: directed byte streams, expected nodes queued, monitor compares.
module tb_rplidar_scan_decoder;

    logic        clk_100mhz = 1'b0;
    logic        reset      = 1'b1;
    logic        restart    = 1'b0;
    logic [7:0]  rx_data    = 8'h00;
    logic        rx_valid   = 1'b0;
    logic        meas_valid;
    logic [5:0]  meas_quality;
    logic        meas_start;
    logic [14:0] meas_angle_q6;
    logic [13:0] meas_distance_mm;
    logic        desc_locked;
    logic [15:0] err_count;

    // 20 us gap at 100 MHz = 2000 cycles keeps the run short
    rplidar_scan_decoder #(
        .CLK_FREQ        (100_000_000),
        .GAP_TIMEOUT_US  (20),
        .SKIP_DESCRIPTOR (1'b1)
    ) dut (
        .clk_100mhz       (clk_100mhz),
        .reset            (reset),
        .restart          (restart),
        .rx_data          (rx_data),
        .rx_valid         (rx_valid),
        .meas_valid       (meas_valid),
        .meas_quality     (meas_quality),
        .meas_start       (meas_start),
        .meas_angle_q6    (meas_angle_q6),
        .meas_distance_mm (meas_distance_mm),
        .desc_locked      (desc_locked),
        .err_count        (err_count)
    );

    always #5 clk_100mhz = ~clk_100mhz;

    typedef struct packed {
        logic [5:0]  q;
        logic        s;
        logic [14:0] a;
        logic [13:0] d;
    } meas_t;

    meas_t exp_q[$];
    int    vectors     = 0;
    int    miscompares = 0;
    logic  prev_rx_valid   = 1'b0;
    logic  prev_meas_valid = 1'b0;

    always @(negedge clk_100mhz) begin
        meas_t got;
        meas_t want;
        if (meas_valid) begin
            got = '{q: meas_quality, s: meas_start, a: meas_angle_q6, d: meas_distance_mm};
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_meas got q=%0d s=%0d a=%h d=%0d, expected no output",
                         got.q, got.s, got.a, got.d);
            end else begin
                want = exp_q.pop_front();
                if (got !== want || !prev_rx_valid || prev_meas_valid) begin
                    miscompares++;
                    $display("FAIL node got q=%0d s=%0d a=%h d=%0d lat_ok=%0d single=%0d, expected q=%0d s=%0d a=%h d=%0d lat_ok=1 single=1",
                             got.q, got.s, got.a, got.d, prev_rx_valid, !prev_meas_valid,
                             want.q, want.s, want.a, want.d);
                end
            end
        end
        prev_rx_valid   <= rx_valid;
        prev_meas_valid <= meas_valid;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk_100mhz);
        #1;
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk_100mhz);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_desc();
        send_byte(8'hA5); send_byte(8'h5A); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h40); send_byte(8'h81);
    endtask

    task automatic send_node(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                             input logic [7:0] b3, input logic [7:0] b4,
                             input logic [5:0] q, input logic s, input logic [14:0] a,
                             input logic [13:0] d);
        send_byte(b0); send_byte(b1); send_byte(b2); send_byte(b3);
        exp_q.push_back('{q: q, s: s, a: a, d: d});
        send_byte(b4);
        repeat (3) @(posedge clk_100mhz);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk_100mhz);
        #1;
        chk("reset_meas_valid", {31'd0, meas_valid}, 32'd0);
        chk("reset_locked", {31'd0, desc_locked}, 32'd0);
        chk("reset_err", {16'd0, err_count}, 32'd0);
        chk("reset_fields", {3'd0, meas_quality, meas_start, meas_angle_q6, meas_distance_mm}, 32'd0);
        reset = 1'b0;

        // garbage, then a repeated sync byte in front of the descriptor
        send_byte(8'h00); send_byte(8'hFF); send_byte(8'hA5);
        send_desc();
        chk("lock_after_garbage", {31'd0, desc_locked}, 32'd1);
        chk("err_after_lock", {16'd0, err_count}, 32'd0);

        send_node(8'h3E, 8'h81, 8'h2D, 8'h40, 8'h1F, 6'd15, 1'b0, 15'h16C0, 14'd2000);
        chk("err_after_n1", {16'd0, err_count}, 32'd0);

        // B0 with S == !S is dropped
        send_byte(8'h03);
        chk("err_bad_b0", {16'd0, err_count}, 32'd1);
        send_node(8'h29, 8'h03, 8'h00, 8'h10, 8'h00, 6'd10, 1'b1, 15'h0001, 14'd4);

        // C = 0 in byte1; 0x02 would be a valid B0 if re-examined
        send_byte(8'h3E); send_byte(8'h02);
        chk("err_bad_c", {16'd0, err_count}, 32'd2);
        send_node(8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 6'd0, 1'b0, 15'h0000, 14'd0);

        // gap shorter than the timeout must not break the node
        send_byte(8'hFE); send_byte(8'hFF); send_byte(8'hFF);
        repeat (1500) @(posedge clk_100mhz);
        send_byte(8'hFF);
        exp_q.push_back('{q: 6'd63, s: 1'b0, a: 15'h7FFF, d: 14'd16383});
        send_byte(8'hFF);
        repeat (3) @(posedge clk_100mhz);
        #1;
        chk("err_short_gap", {16'd0, err_count}, 32'd2);

        // gap longer than the timeout discards the partial node
        send_byte(8'h3E); send_byte(8'h81); send_byte(8'h2D);
        repeat (2500) @(posedge clk_100mhz);
        #1;
        chk("err_gap_timeout", {16'd0, err_count}, 32'd3);
        send_node(8'h45, 8'hD5, 8'h80, 8'h7B, 8'h03, 6'd17, 1'b1, 15'h406A, 14'd222);
        repeat (10) @(posedge clk_100mhz);
        #1;
        chk("hold_angle", {17'd0, meas_angle_q6}, 32'h406A);
        chk("hold_distance", {18'd0, meas_distance_mm}, 32'd222);

        // restart coincident with a sync byte: the byte must not count toward the descriptor
        send_byte(8'h3E); send_byte(8'h81);
        @(posedge clk_100mhz);
        #1;
        rx_data  = 8'hA5;
        rx_valid = 1'b1;
        restart  = 1'b1;
        @(posedge clk_100mhz);
        #1;
        rx_valid = 1'b0;
        restart  = 1'b0;
        chk("restart_unlock", {31'd0, desc_locked}, 32'd0);
        chk("restart_keeps_err", {16'd0, err_count}, 32'd3);
        send_byte(8'h5A); send_byte(8'h05); send_byte(8'h00);
        send_byte(8'h00); send_byte(8'h40); send_byte(8'h81);
        chk("no_lock_without_sync", {31'd0, desc_locked}, 32'd0);
        send_desc();
        chk("relock", {31'd0, desc_locked}, 32'd1);
        send_node(8'h3E, 8'h81, 8'h2D, 8'h40, 8'h1F, 6'd15, 1'b0, 15'h16C0, 14'd2000);

        // 70000 back-to-back bad B0 bytes saturate the error counter
        @(posedge clk_100mhz);
        #1;
        rx_data  = 8'h00;
        rx_valid = 1'b1;
        repeat (70000) @(posedge clk_100mhz);
        #1;
        rx_valid = 1'b0;
        chk("err_saturated", {16'd0, err_count}, 32'h0000FFFF);
        send_node(8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 6'd63, 1'b0, 15'h7FFF, 14'd16383);
        send_byte(8'hFF);
        chk("err_stays_saturated", {16'd0, err_count}, 32'h0000FFFF);

        // reset in the middle of a node
        send_byte(8'h3E); send_byte(8'h81); send_byte(8'h2D); send_byte(8'h40);
        reset = 1'b1;
        repeat (2) @(posedge clk_100mhz);
        #1;
        reset = 1'b0;
        send_byte(8'h1F);
        repeat (3) @(posedge clk_100mhz);
        #1;
        chk("midnode_reset_err", {16'd0, err_count}, 32'd0);
        chk("midnode_reset_locked", {31'd0, desc_locked}, 32'd0);
        chk("midnode_reset_fields", {3'd0, meas_quality, meas_start, meas_angle_q6, meas_distance_mm}, 32'd0);

        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
